fetch_datapath: RTL and testbench

//  Multicycle MIPS fetch/PC stage: holds PC, instruction register (IR), memory data register
//  (MDR) and ALUOut register. Sits directly upstream of the control unit: decodes IR fields

---
 rtl/fetch_datapath.sv | 80 ++++++++
 tb/tb_fetch_datapath.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_datapath.sv
// Multicycle MIPS fetch/PC stage: PC, IR, MDR and ALUOut registers plus IR field decode.
// Sequencing is owned by the control unit; this block only reacts to its strobes.
module fetch_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             Branch,
  input  logic             Zero,
  input  logic             IorD,
  input  logic             IRWrite,
  input  logic [1:0]       PCSrc,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      MemRdata,
  output logic [31:0]      MemAddr,
  output logic [31:0]      pc,
  output logic [5:0]       OPcode,
  output logic [5:0]       funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      imm,
  output logic [31:0]      mdr,
  output logic [31:0]      aluout,
  output logic             pc_misaligned,
  output logic [CNT_W-1:0] instr_count
);

  logic [31:0] ir;
  logic        pc_en;
  logic        pc_load;
  logic [31:0] pc_next;

  // PCSrc=11 is a hold select, so it suppresses the write even when pc_en is set.
  // The jump target uses the registered (old) IR, so a fetch in the same cycle cannot affect it.
  always_comb begin
    pc_en   = PCWrite | (Branch & Zero);
    pc_next = pc;
    unique case (PCSrc)
      2'b00:   pc_next = ALUResult;
      2'b01:   pc_next = aluout;
      2'b10:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      default: pc_next = pc;
    endcase
    pc_load = pc_en & (PCSrc != 2'b11);
  end

  // Reset wins over every enable, discarding any fetch or PC update pending that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      ir          <= '0;
      mdr         <= '0;
      aluout      <= '0;
      instr_count <= '0;
    end else begin
      if (pc_load)
        pc <= pc_next;
      if (IRWrite) begin
        ir <= MemRdata;
        if (instr_count != {CNT_W{1'b1}})
          instr_count <= instr_count + CNT_W'(1);
      end
      mdr    <= MemRdata;
      aluout <= ALUResult;
    end
  end

  assign MemAddr       = IorD ? aluout : pc;
  assign OPcode        = ir[31:26];
  assign rs            = ir[25:21];
  assign rt            = ir[20:16];
  assign rd            = ir[15:11];
  assign imm           = ir[15:0];
  assign funct         = ir[5:0];
  assign pc_misaligned = |pc[1:0];

endmodule

// File: tb/tb_fetch_datapath.sv
// Bench for fetch_datapath: a register-level behavioural model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_fetch_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite, Branch, Zero, IorD, IRWrite;
  logic [1:0]  PCSrc;
  logic [31:0] ALUResult, MemRdata;

  logic [31:0] MemAddr, pc, mdr, aluout;
  logic [5:0]  OPcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        pc_misaligned;
  logic [15:0] instr_count;

  logic [31:0] memAddr4, pc4, mdr4, aluout4;
  logic [5:0]  opcode4, funct4;
  logic [4:0]  rs4, rt4, rd4;
  logic [15:0] imm4;
  logic        misaligned4;
  logic [3:0]  instrCount4;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  fetch_datapath dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .Branch(Branch), .Zero(Zero),
    .IorD(IorD), .IRWrite(IRWrite), .PCSrc(PCSrc), .ALUResult(ALUResult),
    .MemRdata(MemRdata), .MemAddr(MemAddr), .pc(pc), .OPcode(OPcode),
    .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .mdr(mdr),
    .aluout(aluout), .pc_misaligned(pc_misaligned), .instr_count(instr_count)
  );

  fetch_datapath #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .Branch(Branch), .Zero(Zero),
    .IorD(IorD), .IRWrite(IRWrite), .PCSrc(PCSrc), .ALUResult(ALUResult),
    .MemRdata(MemRdata), .MemAddr(memAddr4), .pc(pc4), .OPcode(opcode4),
    .funct(funct4), .rs(rs4), .rt(rt4), .rd(rd4), .imm(imm4), .mdr(mdr4),
    .aluout(aluout4), .pc_misaligned(misaligned4), .instr_count(instrCount4)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Architectural model: what each register must hold after an edge, from the stage's rules.
  logic [31:0] mPc, mIr, mMdr, mAlu;
  int          mCount, mCount4;
  bit          modelValid = 0;

  always @(posedge clk) begin
    if (rst) begin
      mPc        <= 32'h0;
      mIr        <= 32'h0;
      mMdr       <= 32'h0;
      mAlu       <= 32'h0;
      mCount     <= 0;
      mCount4    <= 0;
      modelValid <= 1;
    end else if (modelValid) begin
      if ((PCWrite || (Branch && Zero)) && PCSrc != 2'b11) begin
        if (PCSrc == 2'b00)      mPc <= ALUResult;
        else if (PCSrc == 2'b01) mPc <= mAlu;
        else                     mPc <= (mPc & 32'hF000_0000) | ((mIr & 32'h03FF_FFFF) * 4);
      end
      if (IRWrite) begin
        mIr     <= MemRdata;
        mCount  <= (mCount  < 65535) ? mCount  + 1 : mCount;
        mCount4 <= (mCount4 < 15)    ? mCount4 + 1 : mCount4;
      end
      mMdr <= MemRdata;
      mAlu <= ALUResult;
    end
  end

  // Compare process: outputs are stable mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("pc", pc, mPc);
      checkOutput("OPcode", {26'h0, OPcode}, mIr >> 26);
      checkOutput("rs", {27'h0, rs}, (mIr >> 21) & 32'h1F);
      checkOutput("rt", {27'h0, rt}, (mIr >> 16) & 32'h1F);
      checkOutput("rd", {27'h0, rd}, (mIr >> 11) & 32'h1F);
      checkOutput("imm", {16'h0, imm}, mIr & 32'hFFFF);
      checkOutput("funct", {26'h0, funct}, mIr & 32'h3F);
      checkOutput("mdr", mdr, mMdr);
      checkOutput("aluout", aluout, mAlu);
      checkOutput("MemAddr", MemAddr, IorD ? mAlu : mPc);
      checkOutput("pc_misaligned", {31'h0, pc_misaligned}, {31'h0, (mPc % 4) != 0});
      checkOutput("instr_count", {16'h0, instr_count}, mCount);
      checkOutput("pc_cnt4", pc4, mPc);
      checkOutput("instr_count_cnt4", {28'h0, instrCount4}, mCount4);
    end
  end

  // Drive one cycle's worth of control strobes, then advance past the rising edge.
  task automatic applyStimulus(input logic r, input logic pcw, input logic br, input logic z,
                               input logic iord, input logic irw, input logic [1:0] src,
                               input logic [31:0] alu, input logic [31:0] mem);
    rst = r; PCWrite = pcw; Branch = br; Zero = z; IorD = iord;
    IRWrite = irw; PCSrc = src; ALUResult = alu; MemRdata = mem;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 32'h1234_5678, 32'hFFFF_FFFF);
    checkOutput("reset pc", pc, 32'h0);
    checkOutput("reset OPcode", {26'h0, OPcode}, 32'h0);
    checkOutput("reset funct", {26'h0, funct}, 32'h0);
    checkOutput("reset mdr", mdr, 32'h0);
    checkOutput("reset aluout", aluout, 32'h0);
    checkOutput("reset instr_count", {16'h0, instr_count}, 32'h0);

    // Fetch
    applyStimulus(0, 1, 0, 0, 0, 1, 2'b00, 32'h4, 32'h8C22_0004);
    checkOutput("fetch pc", pc, 32'h4);
    checkOutput("fetch OPcode", {26'h0, OPcode}, 32'h23);
    checkOutput("fetch rs", {27'h0, rs}, 32'h1);
    checkOutput("fetch rt", {27'h0, rt}, 32'h2);
    checkOutput("fetch imm", {16'h0, imm}, 32'h4);
    checkOutput("fetch instr_count", {16'h0, instr_count}, 32'h1);
    checkOutput("fetch MemAddr", MemAddr, 32'h4);

    // Branch taken, branch not taken, hold select
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 32'h20, 32'h0);
    applyStimulus(0, 0, 1, 1, 0, 0, 2'b01, 32'h0, 32'h0);
    checkOutput("beq taken pc", pc, 32'h20);
    applyStimulus(0, 1, 0, 0, 0, 0, 2'b00, 32'h10, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 32'h30, 32'h0);
    applyStimulus(0, 0, 1, 0, 0, 0, 2'b01, 32'h0, 32'h0);
    checkOutput("beq not taken pc", pc, 32'h10);
    applyStimulus(0, 1, 0, 0, 0, 0, 2'b11, 32'h50, 32'h0);
    checkOutput("PCSrc hold pc", pc, 32'h10);

    // Jump, with a simultaneous fetch that must not affect the target
    applyStimulus(0, 1, 0, 0, 0, 1, 2'b00, 32'h4000_0004, 32'h0800_0010);
    checkOutput("jump setup pc", pc, 32'h4000_0004);
    applyStimulus(0, 1, 0, 0, 0, 1, 2'b10, 32'h0, 32'h0800_0100);
    checkOutput("jump pc", pc, 32'h4000_0040);
    checkOutput("jump new OPcode", {26'h0, OPcode}, 32'h2);
    checkOutput("jump new imm", {16'h0, imm}, 32'h0100);

    // Data access through ALUOut
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 32'h100, 32'h0);
    IorD = 1'b1;
    #1;
    checkOutput("data MemAddr", MemAddr, 32'h100);
    applyStimulus(0, 0, 0, 0, 1, 0, 2'b00, 32'h100, 32'hDEAD_BEEF);
    checkOutput("data mdr", mdr, 32'hDEAD_BEEF);
    applyStimulus(0, 1, 0, 0, 0, 0, 2'b00, 32'h2, 32'h0);
    checkOutput("misaligned pc", pc, 32'h2);
    checkOutput("pc_misaligned", {31'h0, pc_misaligned}, 32'h1);

    // Counter saturation on the narrow instance; wide one keeps counting
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 0, 0, 0, 0, 1, 2'b00, 32'h0, 32'h0000_0020 + i);
    checkOutput("saturated instr_count", {28'h0, instrCount4}, 32'hF);
    checkOutput("wide instr_count", {16'h0, instr_count}, 32'd23);

    // Reset during a fetch discards the pending loads
    applyStimulus(1, 1, 0, 0, 0, 1, 2'b00, 32'h8888_8888, 32'hFFFF_FFFF);
    checkOutput("reset-over-fetch pc", pc, 32'h0);
    checkOutput("reset-over-fetch OPcode", {26'h0, OPcode}, 32'h0);
    checkOutput("reset-over-fetch imm", {16'h0, imm}, 32'h0);
    checkOutput("reset-over-fetch instr_count", {16'h0, instr_count}, 32'h0);
    checkOutput("reset-over-fetch cnt4", {28'h0, instrCount4}, 32'h0);

    applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
